// File: rtl/fft_cfg_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_cfg_stream                                               |
// | Description : Packs FFT size, cyclic prefix, FWD/INV flags and (with       |
// |               FFT_CFG_SCALE_EN) the scaling schedule into one AXI4-Stream  |
// |               config word. Range-checks the word before it is sent.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_cfg_stream #(
    parameter int NFFT_W   = 5,
    parameter int CP_W     = 7,
    parameter int CHANNELS = 1,
    parameter int NFFT_MIN = 3,
    parameter int NFFT_MAX = 16,
    localparam int CPF     = 8*((CP_W+7)/8),
    localparam int FWF     = 8*((CHANNELS+7)/8),
`ifdef FFT_CFG_SCALE_EN
    localparam int SCW     = CHANNELS*2*((NFFT_MAX+1)/2),
    localparam int SCF     = 8*((SCW+7)/8),
    localparam int CFG_W   = 8+CPF+FWF+SCF
`else
    localparam int CFG_W   = 8+CPF+FWF
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NFFT_W-1:0]   cfg_nfft,
    input  logic [CP_W-1:0]     cfg_cp_len,
    input  logic [CHANNELS-1:0] cfg_fwd_inv,
`ifdef FFT_CFG_SCALE_EN
    input  logic [SCW-1:0]      cfg_scale_sch,
`endif
    input  logic                cfg_auto,
    input  logic                cfg_trigger,
    output logic                m_axis_tvalid,
    output logic [CFG_W-1:0]    m_axis_tdata,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic                cfg_error,
    output logic [15:0]         sent_count
);

`ifdef FFT_CFG_SCALE_EN
    localparam int LIVE_W = NFFT_W + CP_W + CHANNELS + SCW;
`else
    localparam int LIVE_W = NFFT_W + CP_W + CHANNELS;
`endif
    localparam logic [31:0] NFFT_MIN_U = 32'(NFFT_MIN);
    localparam logic [31:0] NFFT_MAX_U = 32'(NFFT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LIVE_W-1:0]  live;
    logic [LIVE_W-1:0]  last_seen_q, last_seen_d;
    logic [LIVE_W-1:0]  snap_q, snap_d;
    logic               pending_q, pending_d;
    logic               first_q, first_d;
    logic               tvalid_q, tvalid_d;
    logic [CFG_W-1:0]   tdata_q, tdata_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
    logic [15:0]        count_q, count_d;

    logic               req;
    logic               legal;
    logic [CFG_W-1:0]   packed_word;
    logic [NFFT_W-1:0]  snap_nfft;
    logic [CP_W-1:0]    snap_cp;
    logic [CHANNELS-1:0] snap_fwd;
    logic [31:0]        nfft_ext;
    logic [7:0]         f_nfft;
    logic [CPF-1:0]     f_cp;
    logic [FWF-1:0]     f_fwd;
`ifdef FFT_CFG_SCALE_EN
    logic [SCW-1:0]     snap_sch;
    logic [SCF-1:0]     f_sch;
`endif

`ifdef FFT_CFG_SCALE_EN
    assign live     = {cfg_scale_sch, cfg_fwd_inv, cfg_cp_len, cfg_nfft};
    assign snap_sch = snap_q[NFFT_W+CP_W+CHANNELS +: SCW];
`else
    assign live     = {cfg_fwd_inv, cfg_cp_len, cfg_nfft};
`endif
    assign snap_nfft = snap_q[NFFT_W-1:0];
    assign snap_cp   = snap_q[NFFT_W +: CP_W];
    assign snap_fwd  = snap_q[NFFT_W+CP_W +: CHANNELS];
    assign nfft_ext  = 32'(snap_nfft);

    // Comparing with the last attempted setting keeps a rejected word from retrying forever.
    assign req = cfg_trigger | (cfg_auto & ((live != last_seen_q) | first_q));

    // cp_len < 2^nfft is the same as no cp bits surviving a right shift by nfft.
    assign legal = (nfft_ext >= NFFT_MIN_U) && (nfft_ext <= NFFT_MAX_U) &&
                   ((snap_cp >> nfft_ext) == '0);

    always_comb begin
        f_nfft = '0;
        f_nfft[NFFT_W-1:0] = snap_nfft;
        f_cp = '0;
        f_cp[CP_W-1:0] = snap_cp;
        f_fwd = '0;
        f_fwd[CHANNELS-1:0] = snap_fwd;
`ifdef FFT_CFG_SCALE_EN
        f_sch = '0;
        f_sch[SCW-1:0] = snap_sch;
        packed_word = {f_sch, f_fwd, f_cp, f_nfft};
`else
        packed_word = {f_fwd, f_cp, f_nfft};
`endif
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | req;
        first_d     = first_q;
        last_seen_d = last_seen_q;
        snap_d      = snap_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        error_d     = error_q;
        count_d     = count_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q || req) begin
                    state_d     = ST_LOAD;
                    pending_d   = 1'b0;
                    first_d     = 1'b0;
                    snap_d      = live;
                    last_seen_d = live;
                end
            end
            ST_LOAD: begin
                if (legal) begin
                    state_d  = ST_SEND;
                    tvalid_d = 1'b1;
                    tdata_d  = packed_word;
                end else begin
                    state_d  = ST_IDLE;
                    error_d  = 1'b1;
                end
            end
            ST_SEND: begin
                if (tvalid_q && m_axis_tready) begin
                    state_d  = ST_IDLE;
                    tvalid_d = 1'b0;
                    count_d  = count_q + 16'd1;
                    error_d  = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            first_q     <= 1'b1;
            last_seen_q <= '0;
            snap_q      <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            first_q     <= first_d;
            last_seen_q <= last_seen_d;
            snap_q      <= snap_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            count_q     <= count_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign busy          = busy_q;
    assign cfg_error     = error_q;
    assign sent_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_cfg_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_cfg_stream                                            |
// | Description : Directed scoreboard bench for fft_cfg_stream.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_cfg_stream;
`ifdef FFT_CFG_SCALE_EN
    localparam int TW = 40;
`else
    localparam int TW = 24;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    cfg_nfft = '0;
    logic [6:0]    cfg_cp_len = '0;
    logic [0:0]    cfg_fwd_inv = '0;
`ifdef FFT_CFG_SCALE_EN
    logic [15:0]   cfg_scale_sch = '0;
`endif
    logic          cfg_auto = 1'b0;
    logic          cfg_trigger = 1'b0;
    logic          m_axis_tvalid;
    logic [TW-1:0] m_axis_tdata;
    logic          m_axis_tready = 1'b0;
    logic          busy;
    logic          cfg_error;
    logic [15:0]   sent_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [TW-1:0] exp_q[$];

    fft_cfg_stream dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_nfft      (cfg_nfft),
        .cfg_cp_len    (cfg_cp_len),
        .cfg_fwd_inv   (cfg_fwd_inv),
`ifdef FFT_CFG_SCALE_EN
        .cfg_scale_sch (cfg_scale_sch),
`endif
        .cfg_auto      (cfg_auto),
        .cfg_trigger   (cfg_trigger),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .cfg_error     (cfg_error),
        .sent_count    (sent_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented word must match the head of the queue; pop on handshake.
    always @(negedge clk) begin
        if (rst && m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h expected none", m_axis_tdata);
            end else begin
                check("tdata", 64'(m_axis_tdata), 64'(exp_q[0]));
                if (m_axis_tready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_trigger();
        cfg_trigger = 1'b1;
        tick(1);
        cfg_trigger = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(3);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata",  64'(m_axis_tdata),  64'd0);
        check("rst_busy",   64'(busy),          64'd0);
        check("rst_error",  64'(cfg_error),     64'd0);
        check("rst_count",  64'(sent_count),    64'd0);
        rst = 1'b1;
        tick(1);
    endtask

    initial begin
        tick(1);
        do_reset();

        // Single triggered word
        m_axis_tready = 1'b1;
        cfg_nfft = 5'd10; cfg_cp_len = 7'd16; cfg_fwd_inv = 1'b1;
        exp_q.push_back(TW'(24'h01100A));
        pulse_trigger();
        check("t1_busy_load", 64'(busy), 64'd1);
        tick(1);
        check("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
        tick(1);
        check("t1_tvalid_done", 64'(m_axis_tvalid), 64'd0);
        check("t1_count", 64'(sent_count), 64'd1);
        check("t1_error", 64'(cfg_error), 64'd0);
        tick(2);

        // Back-pressure with an auto change during the stall
        m_axis_tready = 1'b0;
        exp_q.push_back(TW'(24'h01100A));
        pulse_trigger();
        tick(1);
        cfg_auto = 1'b1;
        cfg_cp_len = 7'd32;
        exp_q.push_back(TW'(24'h01200A));
        tick(5);
        check("t2_stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("t2_stall_count", 64'(sent_count), 64'd1);
        m_axis_tready = 1'b1;
        tick(6);
        check("t2_count", 64'(sent_count), 64'd3);
        check("t2_idle", 64'(m_axis_tvalid), 64'd0);
        cfg_auto = 1'b0;
        tick(2);

        // Rejected settings, then a legal one clears the error
        cfg_nfft = 5'd17;
        pulse_trigger();
        tick(1);
        check("t3_err_nfft", 64'(cfg_error), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_novalid", 64'(m_axis_tvalid), 64'd0);
        tick(3);
        cfg_nfft = 5'd4; cfg_cp_len = 7'd16;
        pulse_trigger();
        tick(1);
        check("t3_err_cp", 64'(cfg_error), 64'd1);
        tick(2);
        cfg_cp_len = 7'd15;
        exp_q.push_back(TW'(24'h010F04));
        pulse_trigger();
        tick(3);
        check("t3_err_clear", 64'(cfg_error), 64'd0);
        check("t3_count", 64'(sent_count), 64'd4);
        tick(2);

        // Auto after reset sends exactly once
        cfg_auto = 1'b1;
        cfg_nfft = 5'd6; cfg_cp_len = 7'd0; cfg_fwd_inv = 1'b0;
        exp_q.push_back(TW'(24'h000006));
        do_reset();
        tick(55);
        check("t4_count", 64'(sent_count), 64'd1);
        check("t4_idle", 64'(m_axis_tvalid), 64'd0);

        // Reset asserted mid-SEND
        cfg_auto = 1'b0;
        m_axis_tready = 1'b0;
        cfg_nfft = 5'd10; cfg_cp_len = 7'd16; cfg_fwd_inv = 1'b1;
        exp_q.push_back(TW'(24'h01100A));
        pulse_trigger();
        tick(1);
        check("t5_valid", 64'(m_axis_tvalid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_rst_tdata",  64'(m_axis_tdata),  64'd0);
        check("t5_rst_count",  64'(sent_count),    64'd0);
        exp_q.delete();
        tick(2);
        rst = 1'b1;
        tick(2);

`ifdef FFT_CFG_SCALE_EN
        // Scaling schedule field and scale-only change detection
        m_axis_tready = 1'b1;
        cfg_scale_sch = 16'hAAAA;
        cfg_nfft = 5'd16; cfg_cp_len = 7'd0; cfg_fwd_inv = 1'b1;
        exp_q.push_back(40'hAAAA010010);
        pulse_trigger();
        tick(4);
        check("t6_count1", 64'(sent_count), 64'd1);
        cfg_auto = 1'b1;
        tick(3);
        check("t6_no_resend", 64'(sent_count), 64'd1);
        cfg_scale_sch = 16'h5555;
        exp_q.push_back(40'h5555010010);
        tick(5);
        check("t6_count2", 64'(sent_count), 64'd2);
        cfg_auto = 1'b0;
        tick(2);
`endif

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_cfg_stream.md
# fft_cfg_stream

Parametrised driver for the FFT core's AXI4-Stream configuration channel. It packs transform size, cyclic-prefix length, per-channel forward/inverse flags and, optionally, a scaling schedule into one byte-aligned config word. It issues that word on an explicit trigger or automatically when a field changes, and holds it through back-pressure. It sits between the AXI-Lite register file and the FFT core's `s_axis_config_*` port, and rejects out-of-range settings instead of forwarding them.

## Interface
- `NFFT_W`, 5, width of `cfg_nfft` (≤8)
- `CP_W`, 7, width of `cfg_cp_len`
- `CHANNELS`, 1, number of FWD/INV bits
- `NFFT_MIN`, 3, smallest legal log2 transform size
- `NFFT_MAX`, 16, largest legal log2 transform size
- Derived localparams:
  - `CPF = 8*((CP_W+7)/8)`
  - `FWF = 8*((CHANNELS+7)/8)`
  - `SCW = CHANNELS*2*((NFFT_MAX+1)/2)`
  - `SCF = 8*((SCW+7)/8)`
  - `CFG_W = 8+CPF+FWF` (+`SCF` with `FFT_CFG_SCALE_EN`)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `cfg_nfft`  in  NFFT_W  log2 transform size
- `cfg_cp_len`  in  CP_W  cyclic-prefix length
- `cfg_fwd_inv`  in  CHANNELS  1 = forward, per channel
- `cfg_scale_sch`  in  SCW  scaling schedule (only with `FFT_CFG_SCALE_EN`)
- `cfg_auto`  in  1  1 = send automatically on any field change
- `cfg_trigger`  in  1  single-cycle pulse; request a send
- `m_axis_tvalid`  out  1  config word valid
- `m_axis_tdata`  out  CFG_W  packed config word
- `m_axis_tready`  in  1  FFT core accepts word
- `busy`  out  1  high in LOAD or SEND
- `cfg_error`  out  1  sticky; last request rejected
- `sent_count`  out  16  accepted words, wraps 0xFFFF→0

## Operation
- Word layout, LSB first; every field is zero-extended:
  - [7:0] `cfg_nfft`
  - next `CPF` bits: `cfg_cp_len`
  - next `FWF` bits: `cfg_fwd_inv`
  - next `SCF` bits: `cfg_scale_sch` (macro build only)
- Request condition: `cfg_trigger`, or (`cfg_auto` and live fields ≠ `last_seen` register), or (`cfg_auto` and `first` flag set).
  - `first` is set by reset and cleared at the first LOAD.
  - `last_seen` is cleared by reset.
- `pending` flag: set by any request condition; cleared on entering LOAD. One-deep: multiple requests while busy collapse into one.
- State machine, IDLE / LOAD / SEND:
  - IDLE: `pending` or a request this cycle → LOAD. The snapshot register captures live fields on this same edge; `last_seen` ← live fields.
  - LOAD: validate the snapshot.
    - Legal: `NFFT_MIN` ≤ nfft ≤ `NFFT_MAX` and cp_len < 2^nfft. Then → SEND and `m_axis_tdata` ← packed snapshot.
    - Illegal: → IDLE and `cfg_error` ← 1. Nothing is sent.
  - SEND: `m_axis_tvalid` = 1. On `tvalid && tready`: → IDLE, `sent_count`++, `cfg_error` ← 0.
- Field changes or triggers during LOAD/SEND set `pending`. The in-flight word is not altered; a second transfer follows with the new snapshot.
- Comparing against `last_seen` (last attempted, not last sent) stops an illegal setting from retrying forever. The next trigger or change retries it.

## Timing
- Reset (async assert, sync release): state IDLE; `m_axis_tvalid`=0, `m_axis_tdata`=0, `busy`=0, `cfg_error`=0, `sent_count`=0, `pending`=0, `first`=1.
- Reset asserted mid-SEND drops `tvalid` immediately with no completion; `sent_count` is not incremented.
- Latency: request sampled at edge k → LOAD; edge k+1 → SEND. `tvalid` is high in the cycle after k+1. With `tready`=1 the handshake completes at edge k+2; minimum 3 cycles per word.
- AXIS rules:
  - `tdata` is stable while `tvalid`=1 and `tready`=0.
  - `tvalid` never drops without a handshake, except under reset.
  - `tvalid` does not depend combinationally on `tready`.
- Back-to-back: `pending` set during SEND → IDLE→LOAD→SEND, minimum 1 idle cycle between words.
- Reject path: request at edge k → `cfg_error` high after edge k+1; `busy` low after k+1.
- Trigger coinciding with the SEND handshake edge: counts as pending; a second transfer follows.

## Configuration
- `FFT_CFG_SCALE_EN` defined:
  - `cfg_scale_sch` port and `SCF` field present.
  - Schedule participates in change detection.
  - `CFG_W` includes `SCF`.
- Undefined:
  - Port absent, field absent.
  - `CFG_W = 8+CPF+FWF`; 24 bits at defaults.

## Test plan
- Defaults, `cfg_auto`=0, nfft=10, cp=16, fwd=1, trigger pulse → after 2 cycles `tvalid`=1, `tdata`=24'h01100A; `tready`=1 → `sent_count`=1, `cfg_error`=0.
- Back-pressure: `tready`=0 for 5 cycles after `tvalid`; change cp 16→32 with `cfg_auto`=1 during the stall → `tdata` held at 24'h01100A; after accept, second word 24'h01200A; `sent_count`=2.
- Illegal: nfft=17 trigger → no `tvalid`, `cfg_error`=1. Then nfft=4, cp=16 → error stays 1. Then nfft=4, cp=15 → word 24'h010F04 sent, `cfg_error`=0.
- Auto after reset: `cfg_auto`=1, fields static at nfft=6, cp=0, fwd=0 → exactly one word, 24'h000006, then idle for 50 cycles.
- Reset mid-SEND: `tready`=0, `tvalid`=1, assert `rst`=0 between edges → `tvalid`=0 and `tdata`=0 immediately; `sent_count`=0.
- `FFT_CFG_SCALE_EN` build, scale=16'hAAAA, nfft=16, cp=0, fwd=1 → `tdata`=40'hAAAA010010; a scale-only change with `cfg_auto`=1 triggers a resend.
